// File: rtl/pwm_capture.sv
// PWM receiver: recovers the duty code and period of an incoming PWM line and flags stuck inputs by timeout.
// Define PWM_CAPTURE_FILTER_EN to add a 3-sample glitch filter in front of the edge logic.
module pwm_capture #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [7:0]    duty,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          stuck
);

  typedef enum logic {SEEK, MEAS} state_t;

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DMAX = CW'(255);

  state_t        state;
  logic          sync1;
  logic          s;
  logic          lvl;
  logic          lvl_d;
  logic          rise_r;
  logic          edge_r;
  logic [CW-1:0] cnt_per;
  logic [CW-1:0] cnt_hi;
  logic [CW-1:0] idle;
  logic          armed;

`ifdef PWM_CAPTURE_FILTER_EN
  logic s_d;
  logic filt;

  // The next sample of s is already visible in sync1, so three equal samples are sync1, s and s_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d  <= 1'b0;
      filt <= 1'b0;
    end else begin
      s_d <= s;
      if ((sync1 == s) && (s == s_d))
        filt <= s;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s;
`endif

  // Edges are registered, so lvl_d is the level aligned with rise_r/edge_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      lvl_d  <= 1'b0;
      rise_r <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      s      <= sync1;
      lvl_d  <= lvl;
      rise_r <= lvl & ~lvl_d;
      edge_r <= lvl ^ lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SEEK;
      cnt_per <= '0;
      cnt_hi  <= '0;
      idle    <= '0;
      armed   <= 1'b0;
      duty    <= 8'd0;
      period  <= '0;
      valid   <= 1'b0;
      stuck   <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (edge_r) begin
        idle  <= '0;
        armed <= 1'b1;
      end else if (idle != CMAX) begin
        idle <= idle + ONE;
      end

      if (rise_r) begin
        // The first rise only starts a measurement; the partial period before it is never reported.
        if (state == MEAS) begin
          period <= cnt_per;
          duty   <= (cnt_hi > DMAX) ? 8'hff : cnt_hi[7:0];
          stuck  <= 1'b0;
          valid  <= 1'b1;
        end
        cnt_per <= ONE;
        cnt_hi  <= ONE;
        state   <= MEAS;
      end else if (!edge_r && armed && (idle == TLIM)) begin
        duty   <= lvl_d ? 8'hff : 8'h00;
        period <= '0;
        stuck  <= 1'b1;
        valid  <= 1'b1;
        armed  <= 1'b0;
        state  <= SEEK;
      end else if (state == MEAS) begin
        if (cnt_per != CMAX)
          cnt_per <= cnt_per + ONE;
        if (lvl_d && (cnt_hi != CMAX))
          cnt_hi <= cnt_hi + ONE;
      end
    end
  end

endmodule
